// File: rtl/issue_ctrl.sv
// In-order issue controller: register/flags scoreboard, RAW hazard stall,
// control-flow wait/flush sequencing and valid/ready hand-off to execute.
module issue_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [3:0]  LINK_REG     = 4'd15,
    parameter logic [3:0]  COND_ALWAYS  = 4'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic        is_alu_op,
    input  logic        is_not_op,
    input  logic        is_cmp_op,
    input  logic        is_jmp_op,
    input  logic        is_ld_op,
    input  logic        is_str_op,
    input  logic        is_call_op,
    input  logic        is_ret_op,
    input  logic        is_src2_imm,
    input  logic [3:0]  rd,
    input  logic [3:0]  rs,
    input  logic [3:0]  rt,
    input  logic [3:0]  cond,
    input  logic        ex_ready,
    input  logic        wb_valid,
    input  logic [3:0]  wb_rd,
    input  logic        wb_flags,
    input  logic        br_resolved,
    input  logic        br_taken,
    output logic        id_ready,
    output logic        issue_valid,
    output logic        flush,
    output logic [15:0] busy_mask,
    output logic        flags_busy,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT_BR = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] busy_r;
    logic [15:0] busy_nxt_s;
    logic        flags_busy_r;
    logic        flags_busy_nxt_s;
    logic [3:0]  flush_cnt_r;
    logic [3:0]  flush_cnt_nxt_s;

    logic        hazard_s;
    logic        drain_block_s;
    logic        is_ctrl_s;
    logic        dest_en_s;
    logic [3:0]  dest_reg_s;
    logic        issue_valid_s;
    logic        fire_s;
    logic [15:0] clr_mask_s;
    logic [15:0] set_mask_s;

    // Source usage, destination and hazard detection from registered scoreboard only
    always_comb begin
        hazard_s = 1'b0;
        if ((is_alu_op | is_not_op | is_cmp_op | is_ld_op | is_str_op) & busy_r[rs]) begin
            hazard_s = 1'b1;
        end else if ((is_alu_op | is_cmp_op) & ~is_src2_imm & busy_r[rt]) begin
            hazard_s = 1'b1;
        end else if (is_str_op & busy_r[rd]) begin
            hazard_s = 1'b1;
        end else if (is_ret_op & busy_r[LINK_REG]) begin
            hazard_s = 1'b1;
        end else if (is_jmp_op & (cond != COND_ALWAYS) & flags_busy_r) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
        drain_block_s = (is_call_op | is_ret_op) & ((busy_r != 16'd0) | flags_busy_r);
        is_ctrl_s     = is_jmp_op | is_call_op | is_ret_op;
        dest_en_s     = is_alu_op | is_not_op | is_ld_op | is_call_op;
        dest_reg_s    = is_call_op ? LINK_REG : rd;
    end

    // Issue handshake; everything is forced quiet while reset is held
    always_comb begin
        issue_valid_s = rst_n & (state_r == ST_RUN) & id_valid & ~hazard_s & ~drain_block_s;
        fire_s        = issue_valid_s & ex_ready;
        issue_valid   = issue_valid_s;
        id_ready      = fire_s;
        flush         = rst_n & (state_r == ST_FLUSH);
        busy_mask     = busy_r;
        flags_busy    = flags_busy_r;
        state         = state_r;
    end

    // Scoreboard next value: writeback clears, issue sets, set wins on collision
    always_comb begin
        clr_mask_s       = wb_valid ? (16'd1 << wb_rd) : 16'd0;
        set_mask_s       = (fire_s & dest_en_s) ? (16'd1 << dest_reg_s) : 16'd0;
        busy_nxt_s       = (busy_r & ~clr_mask_s) | set_mask_s;
        flags_busy_nxt_s = (flags_busy_r & ~wb_flags) | (fire_s & is_cmp_op);
    end

    // Control-flow sequencing: RUN -> WAIT_BR -> (FLUSH ->) RUN
    always_comb begin
        state_nxt_s     = state_r;
        flush_cnt_nxt_s = flush_cnt_r;
        case (state_r)
            ST_RUN: begin
                if (fire_s & is_ctrl_s) begin
                    state_nxt_s = ST_WAIT_BR;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_WAIT_BR: begin
                if (br_resolved & br_taken) begin
                    state_nxt_s     = ST_FLUSH;
                    flush_cnt_nxt_s = 4'(FLUSH_CYCLES);
                end else if (br_resolved) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_WAIT_BR;
                end
            end
            ST_FLUSH: begin
                // The cycle holding count 1 is the last flush cycle
                if (flush_cnt_r <= 4'd1) begin
                    state_nxt_s     = ST_RUN;
                    flush_cnt_nxt_s = 4'd0;
                end else begin
                    state_nxt_s     = ST_FLUSH;
                    flush_cnt_nxt_s = flush_cnt_r - 4'd1;
                end
            end
            default: begin
                state_nxt_s     = ST_RUN;
                flush_cnt_nxt_s = 4'd0;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_RUN;
            busy_r       <= 16'd0;
            flags_busy_r <= 1'b0;
            flush_cnt_r  <= 4'd0;
        end else begin
            state_r      <= state_nxt_s;
            busy_r       <= busy_nxt_s;
            flags_busy_r <= flags_busy_nxt_s;
            flush_cnt_r  <= flush_cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: per-cycle comparison against a scoreboard-level model
// plus directed scenarios with hand-computed expectations.
module tb_issue_ctrl;

    localparam int FLUSH_N = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic        is_alu_op, is_not_op, is_cmp_op, is_jmp_op;
    logic        is_ld_op, is_str_op, is_call_op, is_ret_op;
    logic        is_src2_imm;
    logic [3:0]  rd, rs, rt, cond;
    logic        ex_ready;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic        wb_flags;
    logic        br_resolved;
    logic        br_taken;
    logic        id_ready;
    logic        issue_valid;
    logic        flush;
    logic [15:0] busy_mask;
    logic        flags_busy;
    logic [1:0]  state;

    int n_vec = 0;
    int n_err = 0;

    // model state: per-register pending flags, flags pending, mode 0=run 1=wait 2=flush
    bit pend [16];
    bit mflags = 1'b0;
    int mode   = 0;
    int left   = 0;

    issue_ctrl #(.FLUSH_CYCLES(FLUSH_N), .LINK_REG(4'd15), .COND_ALWAYS(4'h0)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .is_alu_op(is_alu_op), .is_not_op(is_not_op), .is_cmp_op(is_cmp_op),
        .is_jmp_op(is_jmp_op), .is_ld_op(is_ld_op), .is_str_op(is_str_op),
        .is_call_op(is_call_op), .is_ret_op(is_ret_op), .is_src2_imm(is_src2_imm),
        .rd(rd), .rs(rs), .rt(rt), .cond(cond), .ex_ready(ex_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_flags(wb_flags),
        .br_resolved(br_resolved), .br_taken(br_taken),
        .id_ready(id_ready), .issue_valid(issue_valid), .flush(flush),
        .busy_mask(busy_mask), .flags_busy(flags_busy), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit exp_iv();
        int  srcs[$];
        bit  blocked = 1'b0;
        int  npend   = 0;
        if (!rst_n || mode != 0 || !id_valid) return 1'b0;
        if (is_alu_op || is_cmp_op) begin
            srcs.push_back(int'(rs));
            if (!is_src2_imm) srcs.push_back(int'(rt));
        end
        if (is_not_op || is_ld_op) srcs.push_back(int'(rs));
        if (is_str_op) begin
            srcs.push_back(int'(rs));
            srcs.push_back(int'(rd));
        end
        if (is_ret_op) srcs.push_back(15);
        foreach (srcs[i]) if (pend[srcs[i]]) blocked = 1'b1;
        if (is_jmp_op && cond != 4'h0 && mflags) blocked = 1'b1;
        for (int i = 0; i < 16; i++) npend += int'(pend[i]);
        if ((is_call_op || is_ret_op) && (npend != 0 || mflags)) blocked = 1'b1;
        return !blocked;
    endfunction

    function automatic int exp_dest();
        if (is_alu_op || is_not_op || is_ld_op) return int'(rd);
        if (is_call_op) return 15;
        return -1;
    endfunction

    function automatic logic [15:0] pend_vec();
        logic [15:0] v = 16'd0;
        for (int i = 0; i < 16; i++) v[i] = pend[i];
        return v;
    endfunction

    // model update on the active edge from the inputs held during the cycle
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) pend[i] <= 1'b0;
            mflags <= 1'b0;
            mode   <= 0;
            left   <= 0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (wb_valid && int'(wb_rd) == i) pend[i] <= 1'b0;
                if (exp_iv() && ex_ready && exp_dest() == i) pend[i] <= 1'b1;
            end
            if (wb_flags) mflags <= 1'b0;
            if (exp_iv() && ex_ready && is_cmp_op) mflags <= 1'b1;
            if (mode == 0 && exp_iv() && ex_ready && (is_jmp_op || is_call_op || is_ret_op)) mode <= 1;
            if (mode == 1 && br_resolved) begin
                mode <= br_taken ? 2 : 0;
                left <= FLUSH_N;
            end
            if (mode == 2) begin
                left <= left - 1;
                if (left == 1) mode <= 0;
            end
        end
    end

    // per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("issue_valid", 32'(issue_valid), 32'(exp_iv()));
        chk("id_ready", 32'(id_ready), 32'(exp_iv() && ex_ready));
        chk("flush", 32'(flush), 32'(rst_n && mode == 2));
        chk("busy_mask", 32'(busy_mask), 32'(pend_vec()));
        chk("flags_busy", 32'(flags_busy), 32'(mflags));
        chk("state", 32'(state), 32'(mode));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #3;
    endtask

    task automatic clr_op();
        id_valid = 1'b0; is_alu_op = 1'b0; is_not_op = 1'b0; is_cmp_op = 1'b0;
        is_jmp_op = 1'b0; is_ld_op = 1'b0; is_str_op = 1'b0; is_call_op = 1'b0;
        is_ret_op = 1'b0; is_src2_imm = 1'b0; rd = 4'd0; rs = 4'd0; rt = 4'd0; cond = 4'd0;
    endtask

    task automatic op(input string k, input logic [3:0] d, input logic [3:0] s,
                      input logic [3:0] t, input logic im, input logic [3:0] c);
        clr_op();
        id_valid = 1'b1; rd = d; rs = s; rt = t; is_src2_imm = im; cond = c;
        case (k)
            "alu":   is_alu_op = 1'b1;
            "cmp":   is_cmp_op = 1'b1;
            "ld":    is_ld_op = 1'b1;
            "jmp":   is_jmp_op = 1'b1;
            "call":  is_call_op = 1'b1;
            "ret":   is_ret_op = 1'b1;
            default: is_not_op = 1'b1;
        endcase
    endtask

    task automatic wb(input logic [3:0] r);
        wb_valid = 1'b1; wb_rd = r;
        tick();
        wb_valid = 1'b0; wb_rd = 4'd0;
    endtask

    initial begin
        rst_n = 1'b0; ex_ready = 1'b1; wb_valid = 1'b0; wb_rd = 4'd0; wb_flags = 1'b0;
        br_resolved = 1'b0; br_taken = 1'b0;
        op("alu", 4'd1, 4'd0, 4'd0, 1'b0, 4'd0);
        repeat (2) @(posedge clk);
        #1; look();
        chk("rst_issue_valid", 32'(issue_valid), 32'd0);
        chk("rst_id_ready", 32'(id_ready), 32'd0);
        chk("rst_busy", 32'(busy_mask), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        rst_n = 1'b1;
        tick();

        // independent ops back to back
        op("alu", 4'd1, 4'd0, 4'd0, 1'b0, 4'd0); look();
        chk("indep_first", 32'(issue_valid), 32'd1);
        tick();
        op("alu", 4'd2, 4'd3, 4'd4, 1'b0, 4'd0); look();
        chk("indep_second", 32'(issue_valid), 32'd1);
        tick();
        clr_op(); look();
        chk("indep_busy", 32'(busy_mask), 32'h0006);
        wb(4'd1); wb(4'd2);

        // RAW stall on a load result, no same-cycle bypass
        op("ld", 4'd5, 4'd0, 4'd0, 1'b0, 4'd0); tick();
        op("alu", 4'd6, 4'd5, 4'd0, 1'b0, 4'd0); look();
        chk("raw_stall", 32'(issue_valid), 32'd0);
        tick(); tick();
        wb_valid = 1'b1; wb_rd = 4'd5; look();
        chk("raw_wb_cycle", 32'(issue_valid), 32'd0);
        tick();
        wb_valid = 1'b0; look();
        chk("raw_after_wb", 32'(issue_valid), 32'd1);
        tick();
        clr_op(); wb(4'd6);

        // immediate second source ignores a busy rt
        op("alu", 4'd7, 4'd0, 4'd0, 1'b0, 4'd0); tick();
        op("alu", 4'd8, 4'd2, 4'd7, 1'b1, 4'd0); look();
        chk("imm_no_stall", 32'(issue_valid), 32'd1);
        tick();
        clr_op(); wb(4'd7); wb(4'd8);

        // conditional jump waits for flags, then resolves not taken
        op("cmp", 4'd0, 4'd0, 4'd0, 1'b0, 4'd0); tick();
        op("jmp", 4'd0, 4'd0, 4'd0, 1'b0, 4'h3); look();
        chk("flag_busy", 32'(flags_busy), 32'd1);
        chk("flag_stall", 32'(issue_valid), 32'd0);
        tick();
        wb_flags = 1'b1; look();
        chk("flag_wb_cycle", 32'(issue_valid), 32'd0);
        tick();
        wb_flags = 1'b0; look();
        chk("flag_release", 32'(issue_valid), 32'd1);
        tick();
        clr_op(); br_resolved = 1'b1; br_taken = 1'b0; look();
        chk("nt_wait_state", 32'(state), 32'd1);
        tick();
        br_resolved = 1'b0; look();
        chk("nt_back_run", 32'(state), 32'd0);

        // unconditional jump ignores pending flags; taken branch flushes 2 cycles
        op("cmp", 4'd0, 4'd0, 4'd0, 1'b0, 4'd0); tick();
        op("jmp", 4'd0, 4'd0, 4'd0, 1'b0, 4'h0); look();
        chk("jmp_always", 32'(issue_valid), 32'd1);
        tick();
        op("alu", 4'd9, 4'd0, 4'd0, 1'b0, 4'd0); look();
        chk("wait_id_ready", 32'(id_ready), 32'd0);
        tick(); tick();
        br_resolved = 1'b1; br_taken = 1'b1; look();
        chk("tk_res_flush", 32'(flush), 32'd0);
        tick();
        br_resolved = 1'b0; br_taken = 1'b0; look();
        chk("tk_flush1", 32'(flush), 32'd1);
        chk("tk_flush1_rdy", 32'(id_ready), 32'd0);
        tick(); look();
        chk("tk_flush2", 32'(flush), 32'd1);
        tick(); look();
        chk("tk_flush_end", 32'(flush), 32'd0);
        chk("tk_run", 32'(state), 32'd0);
        clr_op(); wb_flags = 1'b1; tick(); wb_flags = 1'b0;

        // ex_ready low holds the offer without touching the scoreboard
        op("alu", 4'd10, 4'd0, 4'd0, 1'b0, 4'd0); ex_ready = 1'b0; look();
        chk("hold_iv", 32'(issue_valid), 32'd1);
        chk("hold_rdy", 32'(id_ready), 32'd0);
        tick(); look();
        chk("hold_busy", 32'(busy_mask), 32'h0000);
        ex_ready = 1'b1; tick();
        clr_op(); look();
        chk("accept_busy", 32'(busy_mask), 32'h0400);
        wb(4'd10);

        // resolution outside WAIT_BR is ignored
        br_resolved = 1'b1; br_taken = 1'b1; tick();
        br_resolved = 1'b0; br_taken = 1'b0; look();
        chk("run_res_ignored", 32'(state), 32'd0);

        // ret with a clean scoreboard issues and waits
        op("ret", 4'd0, 4'd0, 4'd0, 1'b0, 4'd0); look();
        chk("ret_issue", 32'(issue_valid), 32'd1);
        tick();
        clr_op(); br_resolved = 1'b1; tick(); br_resolved = 1'b0;

        // call drains, sets link register, reset aborts the wait
        op("alu", 4'd4, 4'd0, 4'd0, 1'b0, 4'd0); tick();
        op("call", 4'd0, 4'd0, 4'd0, 1'b0, 4'd0); look();
        chk("call_drain", 32'(issue_valid), 32'd0);
        tick();
        wb_valid = 1'b1; wb_rd = 4'd4; look();
        chk("call_wb_cycle", 32'(issue_valid), 32'd0);
        tick();
        wb_valid = 1'b0; look();
        chk("call_release", 32'(issue_valid), 32'd1);
        tick();
        clr_op(); look();
        chk("call_busy", 32'(busy_mask), 32'h8000);
        chk("call_wait", 32'(state), 32'd1);
        rst_n = 1'b0; tick(); look();
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_busy", 32'(busy_mask), 32'h0000);
        chk("abort_flush", 32'(flush), 32'd0);
        rst_n = 1'b1;
        repeat (3) begin
            tick(); look();
            chk("post_abort_flush", 32'(flush), 32'd0);
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
